pipelined_adder: RTL

- Parametrised, pipelined successor to the combinational half adder: a WIDTH-bit adder with carry-in and carry-out.
- The carry chain is split into STAGES equal chunks. Each chunk is registered, so the design closes timing at wide WIDTH.
- Operands and results move through a valid/ready handshake. Backpressure stalls the whole pipeline.
- Datapath primitive for the arithmetic blocks in the practice tree.

---
 rtl/pipelined_adder.sv | 138 +++++++++++++
 1 files changed

// File: rtl/pipelined_adder.sv
// WIDTH-bit adder whose carry chain is cut into STAGES registered chunks, with a valid/ready handshake.
// Optional signed saturation and overflow flag are enabled by defining ADDER_SAT_EN.
module pipelined_adder #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef ADDER_SAT_EN
    ,
    output logic             ovf
`endif
);
    localparam int unsigned C  = WIDTH / STAGES;
    localparam int unsigned CW = C + 1;

    if (WIDTH < 1 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
        $error("pipelined_adder: need WIDTH >= 1, 1 <= STAGES <= WIDTH, WIDTH %% STAGES == 0");
    end

    logic              advance;
    logic [STAGES-1:0] vld_q, vld_d;
    logic [STAGES-1:0] cry_q, cry_d;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];
    logic [WIDTH-1:0]  a_d [STAGES];
    logic [WIDTH-1:0]  b_d [STAGES];
    logic [WIDTH-1:0]  s_d [STAGES];
    logic [WIDTH-1:0]  sum_d;
    logic              unused_last_ops;

    // The whole pipe moves as one unit whenever the output slot is free or being drained.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // The last stage has no later chunk to feed, so its operand copies are never read.
    assign unused_last_ops = ^{a_q[STAGES-1], b_q[STAGES-1]};

    // Each stage adds its own chunk using the carry registered by the stage before it.
    always_comb begin
        logic [CW-1:0] t;
        logic          c;
        int            p;
        vld_d = '0;
        cry_d = '0;
        t     = '0;
        c     = cin;
        p     = 0;
        for (int i = 0; i < STAGES; i++) begin
            p = (i > 0) ? i - 1 : 0;
            if (i == 0) begin
                vld_d[i] = in_valid;
                a_d[i]   = a;
                b_d[i]   = b;
                s_d[i]   = '0;
                c        = cin;
            end else begin
                vld_d[i] = vld_q[p];
                a_d[i]   = a_q[p];
                b_d[i]   = b_q[p];
                s_d[i]   = s_q[p];
                c        = cry_q[p];
            end
            t = CW'(a_d[i][i*C +: C]) + CW'(b_d[i][i*C +: C]) + CW'(c);
            s_d[i][i*C +: C] = t[C-1:0];
            cry_d[i]         = t[C];
        end
    end

`ifdef ADDER_SAT_EN
    localparam int unsigned     MSB     = WIDTH - 1;
    localparam logic [WIDTH-1:0] MIN_NEG = WIDTH'(1) << MSB;
    localparam logic [WIDTH-1:0] MAX_POS = ~MIN_NEG;

    logic ovf_d;
    logic ovf_q;

    // Signed overflow: like-signed operands producing a result of the opposite sign.
    always_comb begin
        sum_d = s_d[STAGES-1];
        ovf_d = (a_d[STAGES-1][MSB] == b_d[STAGES-1][MSB]) &&
                (s_d[STAGES-1][MSB] != a_d[STAGES-1][MSB]);
        if (ovf_d) begin
            sum_d = a_d[STAGES-1][MSB] ? MIN_NEG : MAX_POS;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (advance) begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    always_comb begin
        sum_d = s_d[STAGES-1];
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            cry_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
                s_q[i] <= '0;
            end
        end else if (advance) begin
            vld_q <= vld_d;
            cry_q <= cry_d;
            for (int i = 0; i < STAGES; i++) begin
                a_q[i] <= a_d[i];
                b_q[i] <= b_d[i];
                s_q[i] <= s_d[i];
            end
            s_q[STAGES-1] <= sum_d;
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign sum       = s_q[STAGES-1];
    assign cout      = cry_q[STAGES-1];

endmodule
